// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use interlock,
// EX-resolved redirects, variable-latency memory wait with timeout halt.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_writeReg,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam logic [8:0]       TIMEOUT_W = 9'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [7:0]       wait_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic mem_stall_s;
    logic lu_hazard_s;
    logic timeout_s;
    logic stall_inc_s;
    logic flush_inc_s;

    assign mem_stall_s = (state_r != ST_HALT) & mem_req & ~mem_ready;
    assign lu_hazard_s = ex_memRead & (ex_writeReg != 5'd0) &
                         ((ex_writeReg == id_rs) | (id_uses_rt & (ex_writeReg == id_rt)));
    // Widened compare so wait_cnt+1 cannot wrap before matching TIMEOUT.
    assign timeout_s   = (({1'b0, wait_cnt_r} + 9'd1) == TIMEOUT_W);
    assign stall_inc_s = (state_r != ST_HALT) & (mem_stall_s | (lu_hazard_s & ~ex_redirect));
    assign flush_inc_s = (state_r != ST_HALT) & ex_redirect & ~mem_stall_s;

    assign state     = state_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; HALT is sticky until reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall_s) begin
                    if (timeout_s) begin
                        next_state_s = ST_HALT;
                    end else begin
                        next_state_s = ST_MEM_WAIT;
                    end
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_RUN;
        endcase
    end

    // Pipeline register controls, highest-priority condition first.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_flush   = 1'b1;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (state_r == ST_HALT) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            halted       = 1'b1;
        end else if (mem_stall_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (lu_hazard_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
        end else begin
            pc_write     = 1'b1;
        end
    end

    // Consecutive memory-wait cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 8'd0;
        end else if (mem_stall_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_memRead;
    logic [4:0] ex_writeReg;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_flush;
    logic       exmem_write;
    logic       memwb_bubble;
    logic       halted;
    logic [1:0] state;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int checks;
    int failures;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_RESET  = 7'b0010101;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_REDIR  = 7'b1111110;
    localparam logic [6:0] C_LU     = 7'b0001110;

    logic [6:0] ctl;
    assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble};

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memRead(ex_memRead), .ex_writeReg(ex_writeReg), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .halted(halted), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memRead = 1'b0; ex_writeReg = 5'd0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        ex_memRead = 1'b1; ex_writeReg = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        clear_inputs();
        #2;
        check_val("rst_ctl", 32'(ctl), 32'(C_RESET));
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_stall", 32'(stall_cnt), 32'd0);
        check_val("rst_flush", 32'(flush_cnt), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check_val("run_ctl", 32'(ctl), 32'(C_NORMAL));

        // Load-use on rs
        set_lu();
        #1;
        check_val("lu_ctl", 32'(ctl), 32'(C_LU));
        step();
        ex_memRead = 1'b0;
        #1;
        check_val("lu_stall", 32'(stall_cnt), 32'd1);
        check_val("lu_after", 32'(ctl), 32'(C_NORMAL));

        // rt dependence only counts when rt is a source; r0 never stalls
        ex_memRead = 1'b1; ex_writeReg = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1;
        check_val("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        id_uses_rt = 1'b0;
        #1;
        check_val("lu_rt_unused", 32'(ctl), 32'(C_NORMAL));
        ex_writeReg = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1;
        check_val("lu_r0", 32'(ctl), 32'(C_NORMAL));
        step();
        check_val("lu_r0_stall", 32'(stall_cnt), 32'd1);
        clear_inputs();

        // Redirect overrides a simultaneous load-use hazard
        set_lu();
        ex_redirect = 1'b1;
        #1;
        check_val("redir_ctl", 32'(ctl), 32'(C_REDIR));
        step();
        check_val("redir_flush", 32'(flush_cnt), 32'd1);
        check_val("redir_stall", 32'(stall_cnt), 32'd1);
        clear_inputs();

        // Memory wait of 3 cycles, redirect held and ignored while frozen
        mem_req = 1'b1; ex_redirect = 1'b1;
        #1;
        check_val("mw_ctl0", 32'(ctl), 32'(C_FREEZE));
        step();
        check_val("mw_state1", 32'(state), 32'd1);
        check_val("mw_ctl1", 32'(ctl), 32'(C_FREEZE));
        step();
        step();
        check_val("mw_state3", 32'(state), 32'd1);
        check_val("mw_stall3", 32'(stall_cnt), 32'd4);
        check_val("mw_flush3", 32'(flush_cnt), 32'd1);
        mem_ready = 1'b1;
        #1;
        check_val("mw_ready_ctl", 32'(ctl), 32'(C_REDIR));
        step();
        check_val("mw_state_run", 32'(state), 32'd0);
        check_val("mw_stall_end", 32'(stall_cnt), 32'd4);
        check_val("mw_flush_end", 32'(flush_cnt), 32'd2);
        clear_inputs();

        // Timeout: HALT after the 4th consecutive wait edge
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check_val("to_state3", 32'(state), 32'd1);
        check_val("to_halted3", 32'(halted), 32'd0);
        step();
        check_val("to_state4", 32'(state), 32'd2);
        check_val("to_halted4", 32'(halted), 32'd1);
        check_val("to_stall4", 32'(stall_cnt), 32'd8);
        mem_ready = 1'b1; ex_redirect = 1'b1;
        #1;
        check_val("halt_ctl", 32'(ctl), 32'(C_FREEZE));
        step();
        check_val("halt_state", 32'(state), 32'd2);
        check_val("halt_stall", 32'(stall_cnt), 32'd8);
        check_val("halt_flush", 32'(flush_cnt), 32'd2);
        clear_inputs();

        // Asynchronous reset from HALT, mid-cycle
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_ctl", 32'(ctl), 32'(C_RESET));
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_halted", 32'(halted), 32'd0);
        check_val("arst_stall", 32'(stall_cnt), 32'd0);
        check_val("arst_flush", 32'(flush_cnt), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check_val("arst_run_ctl", 32'(ctl), 32'(C_NORMAL));
        step();
        check_val("arst_run_state", 32'(state), 32'd0);

        // Saturation of stall_cnt at 15
        set_lu();
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check_val("sat_15", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check_val("sat_hold", 32'(stall_cnt), 32'd15);
        check_val("sat_flush", 32'(flush_cnt), 32'd0);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
